i2s_rx_ctrl_regs: RTL and testbench

AXI4-Lite slave register file for the I2S receiver control port; it is the target of the receiver configuration sequencer. It accepts that sequencer's write/read-back traffic and holds the enable, channel-enable and channel-mux registers that drive the I2S receiver datapath. It also latches an overflow status from the datapath and raises a level interrupt.

---
 rtl/i2s_rx_ctrl_regs.sv | 189 ++++++++++++++++++
 tb/tb_i2s_rx_ctrl_regs.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_ctrl_regs.sv
// AXI4-Lite control register file for the I2S receiver: enable, channel enable,
// channel-mux words, sticky overflow status and a level interrupt.
module i2s_rx_ctrl_regs #(
  parameter logic [31:0] C_VERSION = 32'h0001_0000,
  parameter int          NUM_CHMUX = 6
) (
  input  logic                    s_axi_ctrl_aclk,
  input  logic                    s_axi_ctrl_areset,
  input  logic                    s_axi_ctrl_awvalid,
  output logic                    s_axi_ctrl_awready,
  input  logic [7:0]              s_axi_ctrl_awaddr,
  input  logic                    s_axi_ctrl_wvalid,
  output logic                    s_axi_ctrl_wready,
  input  logic [31:0]             s_axi_ctrl_wdata,
  output logic                    s_axi_ctrl_bvalid,
  input  logic                    s_axi_ctrl_bready,
  output logic [1:0]              s_axi_ctrl_bresp,
  input  logic                    s_axi_ctrl_arvalid,
  output logic                    s_axi_ctrl_arready,
  input  logic [7:0]              s_axi_ctrl_araddr,
  output logic                    s_axi_ctrl_rvalid,
  input  logic                    s_axi_ctrl_rready,
  output logic [31:0]             s_axi_ctrl_rdata,
  output logic [1:0]              s_axi_ctrl_rresp,
  output logic                    core_enable,
  output logic [2:0]              ctrl_mode,
  output logic [3:0]              ch_enable,
  output logic [32*NUM_CHMUX-1:0] ch_mux,
  input  logic                    ovf_pulse,
  output logic                    irq
);

  // Word addresses (byte address >> 2)
  localparam logic [5:0] W_VERSION = 6'h00;
  localparam logic [5:0] W_CTRL    = 6'h02;
  localparam logic [5:0] W_STATUS  = 6'h04;
  localparam logic [5:0] W_IRQ_EN  = 6'h05;
  localparam logic [5:0] W_CH_EN   = 6'h08;
  localparam logic [5:0] W_CHMUX   = 6'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [3:0]  ctrl;
  logic        ovf;
  logic        irq_en;
  logic [3:0]  ch_en;
  logic [31:0] chmux [NUM_CHMUX];

  logic        aw_held, w_held;
  logic [5:0]  awaddr_q;
  logic [31:0] wdata_q;

  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic        wr_fire, wr_err, w1c;
  logic [5:0]  wr_word, rd_word;
  logic [31:0] wr_data, rd_data;
  logic        rd_err;
  logic        unused;

  assign unused = ^{s_axi_ctrl_awaddr[1:0], s_axi_ctrl_araddr[1:0]};

  assign s_axi_ctrl_awready = !aw_held;
  assign s_axi_ctrl_wready  = !w_held;
  assign s_axi_ctrl_arready = !s_axi_ctrl_rvalid;

  assign aw_hs = s_axi_ctrl_awvalid & s_axi_ctrl_awready;
  assign w_hs  = s_axi_ctrl_wvalid  & s_axi_ctrl_wready;
  assign ar_hs = s_axi_ctrl_arvalid & s_axi_ctrl_arready;
  assign b_hs  = s_axi_ctrl_bvalid  & s_axi_ctrl_bready;
  assign r_hs  = s_axi_ctrl_rvalid  & s_axi_ctrl_rready;

  // A live handshake is used directly so AW+W together commit on that same edge.
  assign wr_word = aw_held ? awaddr_q : s_axi_ctrl_awaddr[7:2];
  assign wr_data = w_held  ? wdata_q  : s_axi_ctrl_wdata;
  assign wr_fire = (aw_held | aw_hs) & (w_held | w_hs) & !s_axi_ctrl_bvalid;
  assign rd_word = s_axi_ctrl_araddr[7:2];

  always_comb begin
    wr_err = 1'b1;
    case (wr_word)
      W_CTRL, W_STATUS, W_IRQ_EN, W_CH_EN: wr_err = 1'b0;
      default: begin
        for (int i = 0; i < NUM_CHMUX; i++)
          if (wr_word == 6'(W_CHMUX + i)) wr_err = 1'b0;
      end
    endcase
  end

  assign w1c = wr_fire & !wr_err & (wr_word == W_STATUS) & wr_data[0];

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_word)
      W_VERSION: rd_data = C_VERSION;
      W_CTRL:    rd_data = {28'b0, ctrl};
      W_STATUS:  rd_data = {31'b0, ovf};
      W_IRQ_EN:  rd_data = {31'b0, irq_en};
      W_CH_EN:   rd_data = {28'b0, ch_en};
      default: begin
        rd_err = 1'b1;
        for (int i = 0; i < NUM_CHMUX; i++) begin
          if (rd_word == 6'(W_CHMUX + i)) begin
            rd_data = chmux[i];
            rd_err  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
    if (s_axi_ctrl_areset) begin
      aw_held           <= 1'b0;
      w_held            <= 1'b0;
      awaddr_q          <= '0;
      wdata_q           <= '0;
      s_axi_ctrl_bvalid <= 1'b0;
      s_axi_ctrl_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axi_ctrl_awaddr[7:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_ctrl_wdata;
      end
      if (wr_fire) begin
        s_axi_ctrl_bvalid <= 1'b1;
        s_axi_ctrl_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (b_hs) begin
        s_axi_ctrl_bvalid <= 1'b0;
        aw_held           <= 1'b0;
        w_held            <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
    if (s_axi_ctrl_areset) begin
      ctrl   <= '0;
      irq_en <= 1'b0;
      ch_en  <= '0;
      ovf    <= 1'b0;
      irq    <= 1'b0;
      for (int i = 0; i < NUM_CHMUX; i++) chmux[i] <= '0;
    end else begin
      if (wr_fire && !wr_err) begin
        case (wr_word)
          W_CTRL:   ctrl   <= wr_data[3:0];
          W_IRQ_EN: irq_en <= wr_data[0];
          W_CH_EN:  ch_en  <= wr_data[3:0];
          default: begin
            for (int i = 0; i < NUM_CHMUX; i++)
              if (wr_word == 6'(W_CHMUX + i)) chmux[i] <= wr_data;
          end
        endcase
      end
      // A new overflow event beats a simultaneous clear.
      ovf <= ovf_pulse | (ovf & !w1c);
      irq <= ovf & irq_en;
    end
  end

  always_ff @(posedge s_axi_ctrl_aclk or posedge s_axi_ctrl_areset) begin
    if (s_axi_ctrl_areset) begin
      s_axi_ctrl_rvalid <= 1'b0;
      s_axi_ctrl_rdata  <= '0;
      s_axi_ctrl_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_ctrl_rvalid <= 1'b1;
      s_axi_ctrl_rdata  <= rd_data;
      s_axi_ctrl_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      s_axi_ctrl_rvalid <= 1'b0;
    end
  end

  assign core_enable = ctrl[0];
  assign ctrl_mode   = ctrl[3:1];
  assign ch_enable   = ch_en;

  for (genvar g = 0; g < NUM_CHMUX; g++) begin : g_chmux
    assign ch_mux[g*32 +: 32] = chmux[g];
  end

endmodule

// File: tb/tb_i2s_rx_ctrl_regs.sv
// Self-checking bench for i2s_rx_ctrl_regs: vector table through a response
// scoreboard, plus hand-written timing, backpressure, interrupt and reset cases.
module tb_i2s_rx_ctrl_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [7:0]   awaddr, araddr;
  logic [31:0]  wdata, rdata;
  logic [1:0]   bresp, rresp;
  logic         core_enable, ovf_pulse, irq;
  logic [2:0]   ctrl_mode;
  logic [3:0]   ch_enable;
  logic [191:0] ch_mux;

  int total = 0;
  int bad   = 0;

  logic [1:0]  wexp_q [$];
  logic [33:0] rexp_q [$];

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;
  vec_t vecs [$];

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  always #5 clk = ~clk;

  i2s_rx_ctrl_regs dut (
    .s_axi_ctrl_aclk    (clk),
    .s_axi_ctrl_areset  (rst),
    .s_axi_ctrl_awvalid (awvalid),
    .s_axi_ctrl_awready (awready),
    .s_axi_ctrl_awaddr  (awaddr),
    .s_axi_ctrl_wvalid  (wvalid),
    .s_axi_ctrl_wready  (wready),
    .s_axi_ctrl_wdata   (wdata),
    .s_axi_ctrl_bvalid  (bvalid),
    .s_axi_ctrl_bready  (bready),
    .s_axi_ctrl_bresp   (bresp),
    .s_axi_ctrl_arvalid (arvalid),
    .s_axi_ctrl_arready (arready),
    .s_axi_ctrl_araddr  (araddr),
    .s_axi_ctrl_rvalid  (rvalid),
    .s_axi_ctrl_rready  (rready),
    .s_axi_ctrl_rdata   (rdata),
    .s_axi_ctrl_rresp   (rresp),
    .core_enable        (core_enable),
    .ctrl_mode          (ctrl_mode),
    .ch_enable          (ch_enable),
    .ch_mux             (ch_mux),
    .ovf_pulse          (ovf_pulse),
    .irq                (irq)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic collect_b();
    int n = 0;
    logic [1:0] e;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("bvalid_seen", bvalid, 1'b1);
    e = (wexp_q.size() > 0) ? wexp_q.pop_front() : 2'bxx;
    chk("bresp", bresp, e);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic collect_r(input logic [7:0] a);
    int n = 0;
    logic [33:0] e;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("rvalid_seen", rvalid, 1'b1);
    e = (rexp_q.size() > 0) ? rexp_q.pop_front() : 34'bx;
    chk($sformatf("rdata_%02h", a), rdata, e[33:2]);
    chk($sformatf("rresp_%02h", a), rresp, e[1:0]);
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [1:0] er);
    wexp_q.push_back(er);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    collect_b();
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] er);
    rexp_q.push_back({d, er});
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    collect_r(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; ovf_pulse = 0;
    awaddr = 0; araddr = 0; wdata = 0;

    vecs.push_back('{1, 8'h20, 32'h0000000F, OK});
    vecs.push_back('{0, 8'h20, 32'h0000000F, OK});
    vecs.push_back('{1, 8'h50, 32'h87654321, OK});
    vecs.push_back('{0, 8'h50, 32'h87654321, OK});
    vecs.push_back('{1, 8'h54, 32'h0FEDCBA9, OK});
    vecs.push_back('{0, 8'h54, 32'h0FEDCBA9, OK});
    vecs.push_back('{1, 8'h58, 32'h33221100, OK});
    vecs.push_back('{0, 8'h58, 32'h33221100, OK});
    vecs.push_back('{1, 8'h5C, 32'h77665544, OK});
    vecs.push_back('{0, 8'h5C, 32'h77665544, OK});
    vecs.push_back('{1, 8'h60, 32'hBBAA9988, OK});
    vecs.push_back('{0, 8'h60, 32'hBBAA9988, OK});
    vecs.push_back('{1, 8'h64, 32'hFFEEDDCC, OK});
    vecs.push_back('{0, 8'h64, 32'hFFEEDDCC, OK});
    vecs.push_back('{1, 8'h08, 32'h00000005, OK});
    vecs.push_back('{0, 8'h08, 32'h00000005, OK});
    vecs.push_back('{1, 8'h44, 32'hFFFFFFFF, ERR});
    vecs.push_back('{1, 8'h00, 32'h12345678, ERR});
    vecs.push_back('{1, 8'h68, 32'hDEADBEEF, ERR});
    vecs.push_back('{0, 8'h44, 32'h00000000, ERR});
    vecs.push_back('{0, 8'h68, 32'h00000000, ERR});
    vecs.push_back('{0, 8'h00, 32'h00010000, OK});
    vecs.push_back('{0, 8'h0B, 32'h00000005, OK});
    vecs.push_back('{0, 8'h10, 32'h00000000, OK});
    vecs.push_back('{0, 8'h14, 32'h00000000, OK});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ctrl", {core_enable, ctrl_mode, ch_enable}, 8'h00);
    chk("rst_ch_mux", ch_mux, 192'h0);
    rst = 1'b0;
    tick();

    // AW first, W two cycles later
    awaddr = 8'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw_only_awready", awready, 1'b0);
    chk("aw_only_bvalid", bvalid, 1'b0);
    tick();
    wdata = 32'h5; wvalid = 1'b1;
    chk("aw_wait_bvalid", bvalid, 1'b0);
    tick();
    wvalid = 1'b0;
    chk("late_w_bvalid", bvalid, 1'b1);
    chk("late_w_bresp", bresp, OK);
    chk("late_w_wready", wready, 1'b0);
    chk("late_w_core_enable", core_enable, 1'b1);
    chk("late_w_ctrl_mode", ctrl_mode, 3'b010);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("late_w_bvalid_drop", bvalid, 1'b0);
    chk("late_w_awready_back", awready, 1'b1);
    axi_read(8'h08, 32'h5, OK);

    foreach (vecs[i]) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].resp);
      else            axi_read(vecs[i].addr, vecs[i].data, vecs[i].resp);
    end
    chk("cfg_ch_enable", ch_enable, 4'hF);
    chk("cfg_ch_mux_w0", ch_mux[31:0], 32'h87654321);
    chk("cfg_ch_mux_w5", ch_mux[191:160], 32'hFFEEDDCC);
    chk("cfg_core_enable", core_enable, 1'b1);
    chk("cfg_ctrl_mode", ctrl_mode, 3'b010);

    // Concurrent write + read of CH_EN under 5 cycles of backpressure
    awaddr = 8'h20; wdata = 32'h3; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h20; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_bvalid_%0d", i), bvalid, 1'b1);
      chk($sformatf("bp_rvalid_%0d", i), rvalid, 1'b1);
      chk($sformatf("bp_rdata_%0d", i), rdata, 32'hF);
      chk($sformatf("bp_readys_%0d", i), {awready, wready, arready}, 3'b000);
      tick();
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("bp_valids_drop", {bvalid, rvalid}, 2'b00);
    chk("bp_readys_back", {awready, wready, arready}, 3'b111);
    chk("bp_ch_enable", ch_enable, 4'h3);

    // Overflow interrupt
    axi_write(8'h14, 32'h1, OK);
    ovf_pulse = 1'b1;
    tick();
    ovf_pulse = 1'b0;
    chk("irq_lag", irq, 1'b0);
    tick();
    chk("irq_set", irq, 1'b1);
    axi_read(8'h10, 32'h1, OK);
    axi_write(8'h10, 32'h1, OK);
    chk("irq_cleared", irq, 1'b0);
    axi_read(8'h10, 32'h0, OK);
    ovf_pulse = 1'b1;
    tick();
    ovf_pulse = 1'b0;
    tick();
    chk("irq_reset_again", irq, 1'b1);
    wexp_q.push_back(OK);
    awaddr = 8'h10; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1; ovf_pulse = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; ovf_pulse = 1'b0;
    collect_b();
    axi_read(8'h10, 32'h1, OK);
    chk("irq_set_wins", irq, 1'b1);

    // Reset while a write response is pending
    awaddr = 8'h08; wdata = 32'hA; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("rst_pend_bvalid", bvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_bvalid", bvalid, 1'b0);
    chk("arst_readys", {awready, wready, arready}, 3'b111);
    chk("arst_ctrl", {core_enable, ctrl_mode, ch_enable}, 8'h00);
    chk("arst_ch_mux", ch_mux, 192'h0);
    chk("arst_irq", irq, 1'b0);
    rst = 1'b0;
    tick();
    axi_read(8'h08, 32'h0, OK);
    axi_read(8'h10, 32'h0, OK);
    axi_read(8'h14, 32'h0, OK);
    axi_read(8'h64, 32'h0, OK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
